// File: rtl/stl_uart_packetizer_pkg.sv
// Shared types for the SerialTL byte-stream <-> packet converter.
// RX state encoding matches the debug_state output.
package stl_uart_packetizer_pkg;

    localparam int DEF_PACKET_BYTES = 16;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PRESENT = 2'd1,
        ST_STALL   = 2'd2
    } rx_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stl_uart_packetizer_if.sv
// Byte and packet handshake bundle between the UART handler,
// the packetizer and the UART/TileLink bridges.
interface stl_uart_packetizer_if
    import stl_uart_packetizer_pkg::*;
#(
    parameter int PB = DEF_PACKET_BYTES
);
    logic          data_valid;
    logic          data_ready;
    logic [7:0]    data_in;
    logic          packet_valid;
    logic          packet_ready;
    logic [PB*8-1:0] packet_data;
    logic          tl_response_valid;
    logic          tl_response_ready;
    logic [PB*8-1:0] tl_response_data;
    logic          response_valid;
    logic          response_ready;
    logic [7:0]    response_data;

    modport master (
        output data_valid, data_in, packet_ready,
        output tl_response_valid, tl_response_data,
        output response_ready,
        input  data_ready, packet_valid, packet_data,
        input  tl_response_ready,
        input  response_valid, response_data
    );

    modport slave (
        input  data_valid, data_in, packet_ready,
        input  tl_response_valid, tl_response_data,
        input  response_ready,
        output data_ready, packet_valid, packet_data,
        output tl_response_ready,
        output response_valid, response_data
    );

endinterface

// File: rtl/stl_uart_packetizer_fifo.sv
// Response packet queue with registered full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module stl_uart_packetizer_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic [AW:0]      w_cnt_n;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_cnt_n = r_cnt;
        if (w_push && !w_pop)
            w_cnt_n = r_cnt + 1'b1;
        else if (w_pop && !w_push)
            w_cnt_n = r_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            r_cnt   <= w_cnt_n;
            r_full  <= (w_cnt_n == (AW+1)'(DEPTH));
            r_empty <= (w_cnt_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= i_data;
    end

    assign o_data  = r_mem[r_rp];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/stl_uart_packetizer.sv
// Byte stream <-> packet converter with credit-limited requests,
// inter-byte timeout resync and a multi-packet response queue.
module stl_uart_packetizer
    import stl_uart_packetizer_pkg::*;
#(
    parameter int PACKET_BYTES    = DEF_PACKET_BYTES,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_DEPTH      = 2,
    parameter int TIMEOUT_CYCLES  = 100000
) (
    input  logic clk,
    input  logic reset,
    stl_uart_packetizer_if.slave bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic [7:0] timeout_count,
    output logic [$clog2(PACKET_BYTES+1)-1:0] debug_byte_count,
    output logic [1:0] debug_state
);
    localparam int PW = PACKET_BYTES * 8;
    localparam int CW = $clog2(PACKET_BYTES + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int XW = idx_w(PACKET_BYTES);

    rx_state_t       r_state;
    rx_state_t       w_next;
    logic [PW-1:0]   r_pkt;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_idle;
    logic [7:0]      r_tmo;
    logic [OW-1:0]   r_out;
    logic [XW-1:0]   r_idx;
    logic            w_accept;
    logic            w_last;
    logic            w_idle;
    logic            w_tmo;
    logic            w_pkt_hs;
    logic            w_rsp_hs;
    logic            w_byte_hs;
    logic            w_pop;
    logic            w_credit_full;
    logic            w_full;
    logic            w_empty;
    logic [PW-1:0]   w_head;
    logic [7:0]      w_rsp_byte;

    assign w_accept      = bus.data_valid && (r_state == ST_COLLECT);
    assign w_last        = (r_cnt == CW'(PACKET_BYTES - 1));
    assign w_pkt_hs      = (r_state == ST_PRESENT) && bus.packet_ready;
    assign w_credit_full = (r_out == OW'(MAX_OUTSTANDING));
    assign w_idle        = (r_state == ST_COLLECT) && (r_cnt != '0)
                        && !bus.data_valid;
    assign w_tmo         = w_idle && (r_idle == IW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_COLLECT;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_COLLECT:
                if (w_accept && w_last)
                    w_next = w_credit_full ? ST_STALL : ST_PRESENT;
            ST_PRESENT:
                if (bus.packet_ready)
                    w_next = ST_COLLECT;
            ST_STALL:
                if (!w_credit_full)
                    w_next = ST_PRESENT;
            default:
                w_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt  <= '0;
            r_cnt  <= '0;
            r_idle <= '0;
            r_tmo  <= '0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < PACKET_BYTES; i++)
                    if (r_cnt == CW'(i))
                        r_pkt[8*i +: 8] <= bus.data_in;
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pkt_hs || w_tmo) begin
                r_cnt <= '0;
            end
            // Idle counter only advances while a partial packet is waiting
            if (w_idle && !w_tmo)
                r_idle <= r_idle + 1'b1;
            else
                r_idle <= '0;
            if (w_tmo && (r_tmo != 8'hFF))
                r_tmo <= r_tmo + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else if (w_pkt_hs && !w_rsp_hs) begin
            if (!w_credit_full)
                r_out <= r_out + 1'b1;
        end else if (w_rsp_hs && !w_pkt_hs) begin
            if (r_out != '0)
                r_out <= r_out - 1'b1;
        end
    end

    assign w_rsp_hs  = bus.tl_response_valid && !w_full;
    assign w_byte_hs = !w_empty && bus.response_ready;
    assign w_pop     = w_byte_hs && (r_idx == XW'(PACKET_BYTES - 1));

    stl_uart_packetizer_fifo #(
        .WIDTH (PW),
        .DEPTH (RESP_DEPTH)
    ) u_resp_q (
        .clk     (clk),
        .reset   (reset),
        .i_push  (bus.tl_response_valid),
        .i_data  (bus.tl_response_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_idx <= '0;
        else if (w_pop)
            r_idx <= '0;
        else if (w_byte_hs)
            r_idx <= r_idx + 1'b1;
    end

    // Queue storage is not reset, so the byte is forced to 0 when empty
    always_comb begin
        w_rsp_byte = 8'h00;
        for (int i = 0; i < PACKET_BYTES; i++)
            if (!w_empty && (r_idx == XW'(i)))
                w_rsp_byte = w_head[8*i +: 8];
    end

    assign bus.data_ready        = (r_state == ST_COLLECT) && !reset;
    assign bus.packet_valid      = (r_state == ST_PRESENT);
    assign bus.packet_data       = r_pkt;
    assign bus.tl_response_ready = !w_full;
    assign bus.response_valid    = !w_empty;
    assign bus.response_data     = w_rsp_byte;
    assign outstanding           = r_out;
    assign timeout_count         = r_tmo;
    assign debug_byte_count      = r_cnt;
    assign debug_state           = r_state;

endmodule

// File: tb/tb_stl_uart_packetizer.sv
// Randomised bench for stl_uart_packetizer against a queue-based
// model of the request packets, response bytes and credit count.
module tb_stl_uart_packetizer;
    localparam int PB = 16;
    localparam int MO = 4;
    localparam int RD = 2;
    localparam int TO = 40;
    localparam int OW = $clog2(MO + 1);
    localparam int CW = $clog2(PB + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stl_uart_packetizer_if #(.PB(PB)) bus ();
    logic [OW-1:0] outstanding;
    logic [7:0]    timeout_count;
    logic [CW-1:0] debug_byte_count;
    logic [1:0]    debug_state;

    stl_uart_packetizer #(
        .PACKET_BYTES    (PB),
        .MAX_OUTSTANDING (MO),
        .RESP_DEPTH      (RD),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .outstanding      (outstanding),
        .timeout_count    (timeout_count),
        .debug_byte_count (debug_byte_count),
        .debug_state      (debug_state)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]      cur[$];
    logic [PB*8-1:0] exp_pkts[$];
    logic [PB*8-1:0] got_pkts[$];
    logic [7:0]      exp_bytes[$];
    logic [7:0]      got_bytes[$];
    int m_out, m_idle, m_tmo, m_enq, m_cyc, first_b, last_b;
    bit l_d, l_p, l_r, l_b;

    function automatic logic [PB*8-1:0] rnd_pkt();
        logic [PB*8-1:0] p;
        for (int i = 0; i < PB; i++)
            p[8*i +: 8] = 8'($urandom);
        return p;
    endfunction

    // Sample handshakes mid-cycle, update the model, then cross one edge
    task automatic step();
        logic [PB*8-1:0] p;
        @(negedge clk);
        l_d = bus.data_valid && bus.data_ready;
        l_p = bus.packet_valid && bus.packet_ready;
        l_r = bus.tl_response_valid && bus.tl_response_ready;
        l_b = bus.response_valid && bus.response_ready;
        if (l_d) begin
            m_idle = 0;
            cur.push_back(bus.data_in);
            if (cur.size() == PB) begin
                for (int i = 0; i < PB; i++)
                    p[8*i +: 8] = cur[i];
                exp_pkts.push_back(p);
                cur.delete();
            end
        end else if (cur.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                cur.delete();
                m_idle = 0;
                if (m_tmo < 255) m_tmo++;
            end
        end
        if (l_p) got_pkts.push_back(bus.packet_data);
        if (l_r) begin
            for (int i = 0; i < PB; i++)
                exp_bytes.push_back(bus.tl_response_data[8*i +: 8]);
            m_enq++;
        end
        if (l_b) begin
            got_bytes.push_back(bus.response_data);
            if (first_b < 0) first_b = m_cyc;
            last_b = m_cyc;
        end
        if (l_p && !l_r) m_out++;
        else if (l_r && !l_p && m_out > 0) m_out--;
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        cur.delete(); exp_pkts.delete(); got_pkts.delete();
        exp_bytes.delete(); got_bytes.delete();
        m_out = 0; m_idle = 0; m_tmo = 0; m_enq = 0;
        m_cyc = 0; first_b = -1; last_b = -1;
    endtask

    task automatic idle_inputs();
        bus.data_valid = 0; bus.data_in = 0; bus.packet_ready = 0;
        bus.tl_response_valid = 0; bus.tl_response_data = '0;
        bus.response_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        clear_model();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        bus.data_valid = 1; bus.data_in = b;
        k = 0;
        do begin step(); k++; end while (!l_d && k < 300);
        if (!l_d) begin
            vectors++; miscompares++;
            $display("FAIL send_byte: accepted=0 required=1");
        end
        bus.data_valid = 0;
    endtask

    task automatic wait_pkt();
        int k;
        bus.packet_ready = 1;
        k = 0;
        do begin step(); k++; end while (!l_p && k < 300);
        if (!l_p) begin
            vectors++; miscompares++;
            $display("FAIL wait_pkt: handshake=0 required=1");
        end
    endtask

    task automatic send_resp(input logic [PB*8-1:0] d);
        int k;
        bus.tl_response_valid = 1; bus.tl_response_data = d;
        k = 0;
        do begin step(); k++; end while (!l_r && k < 300);
        if (!l_r) begin
            vectors++; miscompares++;
            $display("FAIL send_resp: handshake=0 required=1");
        end
        bus.tl_response_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step(); step();
        vectors += 10;
        if (bus.data_ready !== 1'b0) begin miscompares++;
            $display("FAIL rst_data_ready: got %b want 0", bus.data_ready); end
        if (bus.packet_valid !== 1'b0) begin miscompares++;
            $display("FAIL rst_packet_valid: got %b want 0", bus.packet_valid); end
        if (bus.packet_data !== '0) begin miscompares++;
            $display("FAIL rst_packet_data: got %h want 0", bus.packet_data); end
        if (bus.tl_response_ready !== 1'b1) begin miscompares++;
            $display("FAIL rst_tl_ready: got %b want 1", bus.tl_response_ready); end
        if (bus.response_valid !== 1'b0) begin miscompares++;
            $display("FAIL rst_resp_valid: got %b want 0", bus.response_valid); end
        if (bus.response_data !== 8'h00) begin miscompares++;
            $display("FAIL rst_resp_data: got %h want 0", bus.response_data); end
        if (outstanding !== '0) begin miscompares++;
            $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        if (timeout_count !== 8'h00) begin miscompares++;
            $display("FAIL rst_timeout: got %0d want 0", timeout_count); end
        if (debug_byte_count !== '0) begin miscompares++;
            $display("FAIL rst_count: got %0d want 0", debug_byte_count); end
        if (debug_state !== 2'd0) begin miscompares++;
            $display("FAIL rst_state: got %0d want 0", debug_state); end
        reset = 0;
        step();
        vectors++;
        if (bus.data_ready !== 1'b1) begin miscompares++;
            $display("FAIL post_rst_data_ready: got %b want 1", bus.data_ready); end
        clear_model();
    endtask

    task automatic test_single_packet();
        logic [PB*8-1:0] want;
        want = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
        do_reset();
        for (int i = 0; i < PB; i++) send_byte(8'(i));
        wait_pkt();
        vectors += 5;
        if (got_pkts.size() != 1) begin miscompares++;
            $display("FAIL single_count: got %0d want 1", got_pkts.size()); end
        else if (got_pkts[0] !== want) begin miscompares++;
            $display("FAIL single_data: got %h want %h", got_pkts[0], want); end
        if (exp_pkts.size() != 1 || exp_pkts[0] !== want) begin miscompares++;
            $display("FAIL single_model: got %0d pkts want 1", exp_pkts.size()); end
        if (outstanding !== OW'(1)) begin miscompares++;
            $display("FAIL single_outstanding: got %0d want 1", outstanding); end
        if (debug_state !== 2'd0) begin miscompares++;
            $display("FAIL single_state: got %0d want 0", debug_state); end
        if (debug_byte_count !== '0) begin miscompares++;
            $display("FAIL single_count0: got %0d want 0", debug_byte_count); end
    endtask

    task automatic test_credit_stall();
        do_reset();
        bus.packet_ready = 1;
        for (int p = 0; p < MO; p++) begin
            for (int i = 0; i < PB; i++) send_byte(8'($urandom));
            wait_pkt();
        end
        for (int i = 0; i < PB; i++) send_byte(8'($urandom));
        step(); step();
        vectors += 4;
        if (outstanding !== OW'(m_out) || m_out != MO) begin miscompares++;
            $display("FAIL stall_out: got %0d want %0d", outstanding, MO); end
        if (debug_state !== 2'd2) begin miscompares++;
            $display("FAIL stall_state: got %0d want 2", debug_state); end
        if (bus.data_ready !== 1'b0) begin miscompares++;
            $display("FAIL stall_ready: got %b want 0", bus.data_ready); end
        if (bus.packet_valid !== 1'b0) begin miscompares++;
            $display("FAIL stall_valid: got %b want 0", bus.packet_valid); end
        send_resp(rnd_pkt());
        vectors += 2;
        if (outstanding !== OW'(MO - 1)) begin miscompares++;
            $display("FAIL stall_credit: got %0d want %0d", outstanding, MO-1); end
        if (debug_state !== 2'd2) begin miscompares++;
            $display("FAIL stall_hold: got %0d want 2", debug_state); end
        step();
        vectors += 2;
        if (debug_state !== 2'd1) begin miscompares++;
            $display("FAIL stall_present: got %0d want 1", debug_state); end
        if (bus.packet_valid !== 1'b1) begin miscompares++;
            $display("FAIL stall_pvalid: got %b want 1", bus.packet_valid); end
        step();
        vectors += 2;
        if (outstanding !== OW'(MO)) begin miscompares++;
            $display("FAIL stall_out_after: got %0d want %0d", outstanding, MO); end
        if (got_pkts.size() != MO + 1 ||
            got_pkts[got_pkts.size()-1] !== exp_pkts[MO]) begin miscompares++;
            $display("FAIL stall_pkt5: got %0d pkts want %0d", got_pkts.size(), MO+1); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.packet_ready = 1;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        for (int k = 0; k < TO - 1; k++) step();
        vectors++;
        if (debug_byte_count !== CW'(cur.size()) || cur.size() != 3) begin
            miscompares++;
            $display("FAIL tmo_before: got %0d want 3", debug_byte_count); end
        step();
        vectors += 2;
        if (debug_byte_count !== CW'(cur.size()) || cur.size() != 0) begin
            miscompares++;
            $display("FAIL tmo_count: got %0d want 0", debug_byte_count); end
        if (timeout_count !== 8'(m_tmo) || m_tmo != 1) begin miscompares++;
            $display("FAIL tmo_counter: got %0d want 1", timeout_count); end
        for (int i = 0; i < PB; i++) send_byte(8'($urandom));
        wait_pkt();
        vectors++;
        if (got_pkts.size() != 1 || exp_pkts.size() != 1 ||
            got_pkts[0] !== exp_pkts[0]) begin miscompares++;
            $display("FAIL tmo_clean_pkt: got %0d pkts want 1", got_pkts.size()); end
    endtask

    task automatic test_back_to_back();
        logic [PB*8-1:0] pk[3];
        int sent, k;
        do_reset();
        for (int i = 0; i < 3; i++) pk[i] = rnd_pkt();
        bus.response_ready = 1;
        bus.tl_response_valid = 1;
        bus.tl_response_data = pk[0];
        sent = 0; k = 0;
        while (got_bytes.size() < 3*PB && k < 400) begin
            step(); k++;
            if (l_r) begin
                sent++;
                if (sent < 3) bus.tl_response_data = pk[sent];
                else bus.tl_response_valid = 0;
                if (sent == 1) begin
                    vectors++;
                    if (bus.response_valid !== 1'b1 ||
                        bus.response_data !== pk[0][7:0]) begin miscompares++;
                        $display("FAIL b2b_first: got %b/%h want 1/%h",
                            bus.response_valid, bus.response_data, pk[0][7:0]); end
                end
            end
            if (m_enq - got_bytes.size() / PB == RD) begin
                vectors++;
                if (bus.tl_response_ready !== 1'b0) begin miscompares++;
                    $display("FAIL b2b_full: got %b want 0", bus.tl_response_ready); end
            end
        end
        vectors += 2;
        if (got_bytes.size() != 3*PB) begin miscompares++;
            $display("FAIL b2b_bytes: got %0d want %0d", got_bytes.size(), 3*PB); end
        if (last_b - first_b + 1 != 3*PB) begin miscompares++;
            $display("FAIL b2b_gaps: got span %0d want %0d", last_b-first_b+1, 3*PB); end
        for (int i = 0; i < got_bytes.size() && i < 3*PB; i++) begin
            vectors++;
            if (got_bytes[i] !== pk[i/PB][8*(i%PB) +: 8]) begin miscompares++;
                $display("FAIL b2b_byte%0d: got %h want %h", i, got_bytes[i],
                    pk[i/PB][8*(i%PB) +: 8]); end
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        send_resp(rnd_pkt());
        vectors++;
        if (outstanding !== '0) begin miscompares++;
            $display("FAIL underflow: got %0d want 0", outstanding); end
        bus.response_ready = 1;
        for (int i = 0; i < PB; i++) send_byte(8'($urandom));
        wait_pkt();
        bus.packet_ready = 0;
        for (int i = 0; i < PB; i++) send_byte(8'($urandom));
        step();
        bus.packet_ready = 1;
        bus.tl_response_valid = 1;
        bus.tl_response_data = rnd_pkt();
        step();
        bus.tl_response_valid = 0;
        vectors += 2;
        if (!(l_p && l_r)) begin miscompares++;
            $display("FAIL same_hs: got %b%b want 11", l_p, l_r); end
        if (outstanding !== OW'(m_out) || m_out != 1) begin miscompares++;
            $display("FAIL same_out: got %0d want 1", outstanding); end
    endtask

    task automatic test_mid_reset();
        logic [157:0] got, want;
        do_reset();
        bus.response_ready = 1;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        send_resp(rnd_pkt());
        step(); step();
        vectors++;
        if (debug_byte_count !== CW'(cur.size()) || bus.response_valid !== 1'b1)
        begin miscompares++;
            $display("FAIL mid_pre: got %0d/%b want %0d/1", debug_byte_count,
                bus.response_valid, cur.size()); end
        reset = 1;
        step();
        got = {bus.data_ready, bus.packet_valid, bus.tl_response_ready,
               bus.response_valid, bus.response_data, outstanding,
               timeout_count, debug_byte_count, debug_state, bus.packet_data};
        want = '0;
        want[155] = 1'b1;
        vectors++;
        if (got !== want) begin miscompares++;
            $display("FAIL mid_reset: got %h want %h", got, want); end
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.data_valid = ((c % 500) < 420) && ($urandom_range(3) != 0);
            bus.data_in = 8'($urandom);
            bus.packet_ready = ($urandom_range(2) != 0);
            bus.tl_response_valid = ($urandom_range(3) == 0);
            bus.tl_response_data = rnd_pkt();
            bus.response_ready = ($urandom_range(1) == 1);
            step();
            vectors += 2;
            if (outstanding !== OW'(m_out)) begin miscompares++;
                $display("FAIL rnd_out@%0d: got %0d want %0d", c, outstanding, m_out); end
            if (timeout_count !== 8'(m_tmo)) begin miscompares++;
                $display("FAIL rnd_tmo@%0d: got %0d want %0d", c, timeout_count, m_tmo); end
        end
        idle_inputs();
        bus.packet_ready = 1;
        bus.response_ready = 1;
        bus.tl_response_valid = 1;
        for (int k = 0; k < 100; k++) step();
        bus.tl_response_valid = 0;
        for (int k = 0; k < 200; k++) step();
        vectors += 2;
        if (got_pkts.size() != exp_pkts.size()) begin miscompares++;
            $display("FAIL rnd_npkts: got %0d want %0d", got_pkts.size(), exp_pkts.size()); end
        if (got_bytes.size() != exp_bytes.size()) begin miscompares++;
            $display("FAIL rnd_nbytes: got %0d want %0d", got_bytes.size(), exp_bytes.size()); end
        for (int i = 0; i < got_pkts.size() && i < exp_pkts.size(); i++) begin
            vectors++;
            if (got_pkts[i] !== exp_pkts[i]) begin miscompares++;
                $display("FAIL rnd_pkt%0d: got %h want %h", i, got_pkts[i], exp_pkts[i]); end
        end
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
            vectors++;
            if (got_bytes[i] !== exp_bytes[i]) begin miscompares++;
                $display("FAIL rnd_byte%0d: got %h want %h", i, got_bytes[i], exp_bytes[i]); end
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_single_packet();
        test_credit_stall();
        test_timeout();
        test_back_to_back();
        test_same_cycle();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
